// File: rtl/reload_down_timer.sv
// reload_down_timer: programmable down-counting timer with a valid/ready
// reload port and auto-reload on terminal count. It emits a one-cycle
// expire pulse at the end of every period.
//
// Optional feature macro: RELOAD_TIMER_EXPCNT_EN. When it is defined, the
// block adds an 8-bit saturating count of expire pulses (expire_cnt_o).
// The count clears on every accepted load.

module reload_down_timer #(
    parameter int WIDTH = 4  // legal range 2..16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             start_i,
    input  logic             stop_i,
    output logic [WIDTH-1:0] count_o,
    output logic             expire_o,
    output logic             busy_o
`ifdef RELOAD_TIMER_EXPCNT_EN
    ,
    output logic [7:0]       expire_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // never loaded since reset
        ST_ARMED = 2'd1,  // holds a period, paused
        ST_RUN   = 2'd2   // counting down
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;

    logic load_accept;
    logic go;
    logic at_zero;

    // A load is taken only while not running; stop overrides start.
    assign load_accept = load_valid_i && (state_q != ST_RUN);
    assign go          = start_i && !stop_i;
    assign at_zero     = (count_q == '0);

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign load_ready_o = (state_q != ST_RUN);
    assign busy_o       = (state_q == ST_RUN);
    assign expire_o     = (state_q == ST_RUN) && at_zero;
    assign count_o      = count_q;

    // Main FSM: loads, start/stop handling, decrement and auto-reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            unique case (state_q)
                ST_IDLE: begin
                    // start/stop are ignored here; only a load moves on.
                    if (load_accept) begin
                        reload_q <= load_val_i;
                        count_q  <= load_val_i;
                        state_q  <= go ? ST_RUN : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (load_accept) begin
                        reload_q <= load_val_i;
                        count_q  <= load_val_i;
                        state_q  <= go ? ST_RUN : ST_ARMED;
                    end else if (go) begin
                        // Resume from the held count; no reload on resume.
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The count update happens even on the edge that stops.
                    if (at_zero) begin
                        count_q <= reload_q;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                    if (stop_i) begin
                        state_q <= ST_ARMED;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RELOAD_TIMER_EXPCNT_EN
    logic [7:0] expire_cnt_q;

    // Saturating expire-pulse counter, cleared by every accepted load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expire_cnt_q <= 8'd0;
        end else if (load_accept) begin
            expire_cnt_q <= 8'd0;
        end else if (expire_o && (expire_cnt_q != 8'hFF)) begin
            expire_cnt_q <= expire_cnt_q + 8'd1;
        end
    end

    assign expire_cnt_o = expire_cnt_q;
`endif

endmodule

// File: tb/tb_reload_down_timer.sv
// Directed testbench for reload_down_timer (WIDTH = 4). A table of
// per-cycle vectors covers the main load/start/stop behaviour. Hand-written
// sequences cover async reset, zero reload, maximum period, and (with
// RELOAD_TIMER_EXPCNT_EN) saturation of the expire counter.

module tb_reload_down_timer;

    localparam int WIDTH = 4;

    logic             clk;
    logic             reset_n;
    logic             load_valid_i;
    logic             load_ready_o;
    logic [WIDTH-1:0] load_val_i;
    logic             start_i;
    logic             stop_i;
    logic [WIDTH-1:0] count_o;
    logic             expire_o;
    logic             busy_o;
`ifdef RELOAD_TIMER_EXPCNT_EN
    logic [7:0]       expire_cnt_o;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    reload_down_timer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_val_i   (load_val_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .count_o      (count_o),
        .expire_o     (expire_o),
        .busy_o       (busy_o)
`ifdef RELOAD_TIMER_EXPCNT_EN
        ,
        .expire_cnt_o (expire_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: inputs were driven at a negedge; this passes the posedge
    // and returns at the next negedge, where outputs are sampled.
    typedef struct {
        logic             lv;
        logic [WIDTH-1:0] val;
        logic             st;
        logic             sp;
        logic [WIDTH-1:0] cnt;
        logic             ex;
        logic             bz;
        logic             rd;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic lv, input logic [WIDTH-1:0] val, input logic st, input logic sp);
        load_valid_i = lv;
        load_val_i   = val;
        start_i      = st;
        stop_i       = sp;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] cnt,
                              input logic ex, input logic bz, input logic rd);
        check({tag, ".count"},  32'(count_o),      32'(cnt));
        check({tag, ".expire"}, 32'(expire_o),     32'(ex));
        check({tag, ".busy"},   32'(busy_o),       32'(bz));
        check({tag, ".ready"},  32'(load_ready_o), 32'(rd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    function automatic void add(input logic lv, input logic [WIDTH-1:0] val, input logic st,
                                input logic sp, input logic [WIDTH-1:0] cnt, input logic ex,
                                input logic bz, input logic rd);
        vec_t v;
        v.lv = lv; v.val = val; v.st = st; v.sp = sp;
        v.cnt = cnt; v.ex = ex; v.bz = bz; v.rd = rd;
        vecs.push_back(v);
    endfunction

    initial begin
        int first_exp;
        int period;
        int cyc;

        reset_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        #12;
        @(negedge clk);
        reset_n = 1'b1;

        // Reset state.
        check_outs("reset", 4'd0, 1'b0, 1'b0, 1'b1);

        // ---------------- Table-driven main sequence ----------------
        //   lv  val   st  sp   | cnt  ex  bz  rd
        add(1, 4'd3, 0, 0,  4'd3, 0, 0, 1);  // load 3 -> ARMED
        add(0, 4'd0, 0, 0,  4'd3, 0, 0, 1);  // hold
        add(0, 4'd0, 1, 0,  4'd3, 0, 1, 0);  // start -> RUN, no decrement yet
        add(0, 4'd0, 0, 0,  4'd2, 0, 1, 0);
        add(0, 4'd0, 0, 0,  4'd1, 0, 1, 0);
        add(0, 4'd0, 0, 0,  4'd0, 1, 1, 0);  // terminal count
        add(0, 4'd0, 0, 0,  4'd3, 0, 1, 0);  // auto-reload
        add(0, 4'd0, 0, 0,  4'd2, 0, 1, 0);
        add(0, 4'd0, 0, 0,  4'd1, 0, 1, 0);
        add(0, 4'd0, 0, 0,  4'd0, 1, 1, 0);  // period of 4
        add(0, 4'd0, 0, 0,  4'd3, 0, 1, 0);
        add(0, 4'd0, 0, 0,  4'd2, 0, 1, 0);  // count 2
        add(1, 4'd9, 0, 0,  4'd1, 0, 1, 0);  // load refused while running
        add(1, 4'd9, 0, 1,  4'd0, 0, 0, 1);  // stop: count still updates, ARMED
        add(1, 4'd9, 0, 0,  4'd9, 0, 0, 1);  // load now accepted
        add(1, 4'd1, 0, 0,  4'd1, 0, 0, 1);  // reload with 1
        add(0, 4'd0, 1, 0,  4'd1, 0, 1, 0);  // start
        add(0, 4'd0, 0, 0,  4'd0, 1, 1, 0);  // expire visible
        add(0, 4'd0, 1, 1,  4'd1, 0, 0, 1);  // stop+start at zero: reload, ARMED
        add(0, 4'd0, 0, 0,  4'd1, 0, 0, 1);  // paused, holds
        add(0, 4'd0, 1, 0,  4'd1, 0, 1, 0);  // resume without extra reload
        add(0, 4'd0, 0, 0,  4'd0, 1, 1, 0);
        add(0, 4'd0, 0, 0,  4'd1, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].lv, vecs[i].val, vecs[i].st, vecs[i].sp);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ex, vecs[i].bz, vecs[i].rd);
        end

        // ---------------- Async reset mid-run ----------------
        do_reset();
        drive(1'b1, 4'd5, 1'b1, 1'b0);
        step();
        check_outs("rst.load", 4'd5, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        step(); step(); step();
        check_outs("rst.run3", 4'd2, 1'b0, 1'b1, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outs("rst.async", 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        reset_n = 1'b1;
        drive(1'b0, 4'd0, 1'b1, 1'b0);  // start alone is ignored in IDLE
        step(); step();
        check_outs("rst.idle_start", 4'd0, 1'b0, 1'b0, 1'b1);

        // ---------------- Zero reload with start ----------------
        do_reset();
        drive(1'b1, 4'd0, 1'b1, 1'b0);
        step();
        check_outs("zero.entry", 4'd0, 1'b1, 1'b1, 1'b0);
`ifdef RELOAD_TIMER_EXPCNT_EN
        check("zero.cnt0", 32'(expire_cnt_o), 32'd0);
`endif
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check_outs("zero.hold", 4'd0, 1'b1, 1'b1, 1'b0);
`ifdef RELOAD_TIMER_EXPCNT_EN
        check("zero.cnt10", 32'(expire_cnt_o), 32'd10);
        for (int i = 0; i < 290; i++) step();
        check("zero.sat", 32'(expire_cnt_o), 32'd255);
        drive(1'b0, 4'd0, 1'b0, 1'b1);  // stop
        step();
        check("zero.sat_hold", 32'(expire_cnt_o), 32'd255);
        drive(1'b1, 4'd7, 1'b0, 1'b0);  // accepted load clears
        step();
        check("zero.clear", 32'(expire_cnt_o), 32'd0);
        check("zero.clear_count", 32'(count_o), 32'd7);
`endif

        // ---------------- Maximum period ----------------
        do_reset();
        drive(1'b1, 4'd15, 1'b1, 1'b0);
        step();
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        first_exp = -1;
        cyc = 0;
        while (first_exp < 0 && cyc < 40) begin
            step();
            cyc++;
            if (expire_o) first_exp = cyc;
        end
        check("max.first", 32'(first_exp), 32'd15);
        period = -1;
        cyc = 0;
        while (period < 0 && cyc < 40) begin
            step();
            cyc++;
            if (expire_o) period = cyc;
        end
        check("max.period", 32'(period), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
